gpu_gpr_bank: RTL and testbench
===============================

GPU_GPR_BANK -- requirements
Module: gpu_gpr_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 64 (`GPU_DDATA_WIDTH), register width in bits, multiple of 8.
REQ-002 SHALL have parameter REG_NUM, default 32, registers per context, power of 2, at least 2.
REQ-003 SHALL have parameter CTX_NUM, default 4, independent register contexts (warps), power of 2.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clk_en  in  1  pipeline advance enable.
- init_done  out  1  clear sweep complete.
- wr_en  in  1  write request.
- wr_ctx  in  log2(CTX_NUM)  write context.
- wr_addr  in  log2(REG_NUM)  write register index.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte write enables.
- rd_en  in  1  read request.
- rd_ctx  in  log2(CTX_NUM)  read context.
- rs1_addr, rs2_addr  in  log2(REG_NUM)  read register indices.
- rs1_data, rs2_data  out  DATA_W  registered read data.
- rd_valid  out  1  read data valid.
REQ-005 SHALL use one clock (clk) and a synchronous, active-low reset (rst_n); no other clock or reset.

Function
REQ-006 SHALL contain an FSM with states INIT and RUN.
REQ-007 INIT: clear one entry per clk cycle, independent of clk_en, through all CTX_NUM*REG_NUM entries via an internal counter; enter RUN on the last entry; init_done asserts on the first RUN cycle.
REQ-008 SHALL ignore wr_en and rd_en in INIT; rd_valid stays 0 throughout INIT.
REQ-009 RUN: a write commits on the clk edge when clk_en=1, wr_en=1 and wr_addr!=0; only bytes with wr_be[i]=1 update.
REQ-010 Register 0 of every context SHALL read as 0; writes to it are dropped.
REQ-011 Read latency SHALL be 1 cycle: rd_en=1 with clk_en=1 at edge N gives rs1_data/rs2_data and rd_valid=1 after edge N.
REQ-012 clk_en=1 with rd_en=0 SHALL clear rd_valid and hold rs1_data/rs2_data.
REQ-013 clk_en=0 SHALL hold rs1_data, rs2_data and rd_valid, and block all writes.
REQ-014 rs1_addr equal to rs2_addr SHALL return identical data on both ports.
REQ-015 Contexts SHALL be isolated: a write to ctx A never changes a read of ctx B.
REQ-016 Write and read to the same ctx/addr in the same cycle: behaviour per REQ-020/REQ-021.

Reset
REQ-017 rst_n=0 at a clk edge SHALL force: state INIT, sweep counter 0, init_done=0, rd_valid=0, rs1_data=0, rs2_data=0.
REQ-018 Reset asserted mid-sweep or in RUN SHALL restart the full sweep from entry 0; no partial contents are guaranteed before the new init_done.
REQ-019 Storage SHALL NOT require reset itself; zeroing happens only through the sweep.

Configuration
REQ-020 With macro GPR_BYPASS_EN defined, a same-cycle write and read hit SHALL return merged data: new bytes where wr_be=1, old bytes elsewhere; register 0 still reads 0.
REQ-021 Without GPR_BYPASS_EN, a same-cycle hit SHALL return the pre-write value; the new value is visible from the next read.

Verification
REQ-022 Reset, CTX_NUM=4, REG_NUM=32 -> init_done rises exactly 128 cycles after rst_n release; every read afterwards returns 0.
REQ-023 Write ctx1 r5=0x1122334455667788 with wr_be=0xFF, then read ctx1 rs1=r5, rs2=r0 -> next cycle rs1=0x1122334455667788, rs2=0, rd_valid=1; ctx2 r5 reads 0.
REQ-024 Write r7=0xFFFF..FF, then wr_be=0x0F with data 0 -> r7 reads 0xFFFFFFFF00000000.
REQ-025 Same-cycle write ctx0 r3=0xAA (wr_be=0x01, old 0) with read ctx0 r3 -> 0xAA with GPR_BYPASS_EN, 0x00 without it.
REQ-026 clk_en=0 for 3 cycles during a write+read -> outputs frozen, no write; pulse rst_n=0 at sweep entry 60 -> sweep restarts, init_done at 128 cycles after release.

Source files
------------

// File: rtl/gpu_gpr_bank.sv
// Per-context GPU general-purpose register bank: byte-lane storage, 2 read ports, 1 write port, zeroing sweep after reset.
// Optional macro GPR_BYPASS_EN forwards same-cycle write data (byte-merged) to the read ports.
`ifndef GPU_DDATA_WIDTH
`define GPU_DDATA_WIDTH 64
`endif

module gpu_gpr_bank #(
  parameter int DATA_W  = `GPU_DDATA_WIDTH,
  parameter int REG_NUM = 32,
  parameter int CTX_NUM = 4,
  localparam int CTX_W  = (CTX_NUM > 1) ? $clog2(CTX_NUM) : 1,
  localparam int ADDR_W = $clog2(REG_NUM),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  output logic              init_done,
  input  logic              wr_en,
  input  logic [CTX_W-1:0]  wr_ctx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [CTX_W-1:0]  rd_ctx,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_valid
);

  localparam int DEPTH = CTX_NUM * REG_NUM;
  localparam int IDX_W = CTX_W + ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   sweep_cnt_reg;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [DATA_W-1:0]  mem_wdata;
  logic [NB-1:0]      mem_be;
  logic [IDX_W-1:0]   rd1_idx, rd2_idx;
  logic [DATA_W-1:0]  rd1_merged, rd2_merged;
  logic [DATA_W-1:0]  rd1_val, rd2_val;

  // The sweep owns the write port in INIT; user writes are ignored there.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = {wr_ctx, wr_addr};
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (rst_n) begin
      if (state_reg == INIT) begin
        mem_we    = 1'b1;
        mem_idx   = sweep_cnt_reg;
        mem_wdata = '0;
        mem_be    = '1;
      end else begin
        mem_we = clk_en && wr_en && (wr_addr != '0);
      end
    end
  end

  assign rd1_idx = {rd_ctx, rs1_addr};
  assign rd2_idx = {rd_ctx, rs2_addr};

`ifdef GPR_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = wr_en && (wr_addr != '0) && (wr_ctx == rd_ctx) && (wr_addr == rs1_addr);
  assign hit2 = wr_en && (wr_addr != '0) && (wr_ctx == rd_ctx) && (wr_addr == rs2_addr);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we && mem_be[gi])
          lane_mem[mem_idx] <= mem_wdata[gi*8 +: 8];
      end

`ifdef GPR_BYPASS_EN
      assign rd1_merged[gi*8 +: 8] = (hit1 && wr_be[gi]) ? wr_data[gi*8 +: 8] : lane_mem[rd1_idx];
      assign rd2_merged[gi*8 +: 8] = (hit2 && wr_be[gi]) ? wr_data[gi*8 +: 8] : lane_mem[rd2_idx];
`else
      assign rd1_merged[gi*8 +: 8] = lane_mem[rd1_idx];
      assign rd2_merged[gi*8 +: 8] = lane_mem[rd2_idx];
`endif
    end
  endgenerate

  // Register 0 is hardwired to zero regardless of what the storage holds.
  assign rd1_val = (rs1_addr == '0) ? '0 : rd1_merged;
  assign rd2_val = (rs2_addr == '0) ? '0 : rd2_merged;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      init_done     <= 1'b0;
      rd_valid      <= 1'b0;
      rs1_data      <= '0;
      rs2_data      <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          rd_valid      <= 1'b0;
          sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          if (sweep_cnt_reg == IDX_W'(DEPTH - 1)) begin
            state_reg <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (clk_en) begin
            if (rd_en) begin
              rs1_data <= rd1_val;
              rs2_data <= rd2_val;
              rd_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
            end
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_gpr_bank.sv
// Randomized + directed bench for gpu_gpr_bank against an array-based register model.
// Build with +define+GPR_BYPASS_EN to check the forwarding variant.
module tb_gpu_gpr_bank;
  localparam int DW = 64;
  localparam int RN = 32;
  localparam int CN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          init_done;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ctx = '0;
  logic [4:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_ctx = '0;
  logic [4:0]    rs1_addr = '0;
  logic [4:0]    rs2_addr = '0;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          rd_valid;

  always #5 clk = ~clk;

  gpu_gpr_bank dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .init_done(init_done),
    .wr_en(wr_en), .wr_ctx(wr_ctx), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_ctx(rd_ctx), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid)
  );

  logic [DW-1:0] ref_mem [CN][RN];
  logic [DW-1:0] exp_rs1, exp_rs2;
  logic          exp_valid;
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_read(input logic [1:0] ctx, input logic [4:0] addr);
    if (addr == 0) return 64'd0;
`ifdef GPR_BYPASS_EN
    if (wr_en && wr_addr != 0 && wr_ctx == ctx && wr_addr == addr)
      return merge(ref_mem[ctx][addr], wr_data, wr_be);
`endif
    return ref_mem[ctx][addr];
  endfunction

  // One RUN-mode clock: predict from current inputs, clock, compare, report the transaction.
  task automatic run_cycle();
    if (clk_en) begin
      if (rd_en) begin
        exp_rs1   = model_read(rd_ctx, rs1_addr);
        exp_rs2   = model_read(rd_ctx, rs2_addr);
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (wr_en && wr_addr != 0)
        ref_mem[wr_ctx][wr_addr] = merge(ref_mem[wr_ctx][wr_addr], wr_data, wr_be);
    end
    @(posedge clk); #1;
    $display("cyc ce=%0b wr=%0b c%0d r%0d d=%h be=%h rd=%0b c%0d r%0d/r%0d -> %h %h v=%0b",
             clk_en, wr_en, wr_ctx, wr_addr, wr_data, wr_be, rd_en, rd_ctx, rs1_addr, rs2_addr,
             rs1_data, rs2_data, rd_valid);
    check_val("rs1", rs1_data, exp_rs1);
    check_val("rs2", rs2_data, exp_rs2);
    check_val("rd_valid", {63'd0, rd_valid}, {63'd0, exp_valid});
  endtask

  task automatic randomize_inputs(input int max_addr);
    clk_en   = ($urandom_range(0, 9) < 8);
    wr_en    = $urandom_range(0, 1);
    wr_ctx   = 2'($urandom_range(0, CN - 1));
    wr_addr  = 5'($urandom_range(0, max_addr));
    wr_data  = {$urandom, $urandom};
    wr_be    = 8'($urandom);
    rd_en    = ($urandom_range(0, 9) < 7);
    rd_ctx   = 2'($urandom_range(0, CN - 1));
    rs1_addr = 5'($urandom_range(0, max_addr));
    rs2_addr = 5'($urandom_range(0, max_addr));
  endtask

  // Counts edges from rst_n release until init_done, with garbage traffic that must be ignored.
  task automatic wait_init(input string tag);
    int cnt = 0;
    int bad_valid = 0;
    rst_n = 1'b1;
    while (!init_done && cnt < 300) begin
      randomize_inputs(RN - 1);
      @(posedge clk); #1;
      cnt++;
      if (rd_valid) bad_valid++;
    end
    $display("init %s: init_done after %0d cycles", tag, cnt);
    check_val({tag, "_init_cycles"}, 64'(cnt), 64'd128);
    check_val({tag, "_valid_in_init"}, 64'(bad_valid), 64'd0);
    for (int c = 0; c < CN; c++)
      for (int r = 0; r < RN; r++) ref_mem[c][r] = '0;
    exp_rs1 = '0; exp_rs2 = '0; exp_valid = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clk_en = 1'b1;
  endtask

  task automatic set_write(input logic en, input logic [1:0] c, input logic [4:0] a,
                           input logic [63:0] d, input logic [7:0] be);
    wr_en = en; wr_ctx = c; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic set_read(input logic en, input logic [1:0] c, input logic [4:0] a1, input logic [4:0] a2);
    rd_en = en; rd_ctx = c; rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_init_done", {63'd0, init_done}, 64'd0);
    check_val("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_val("rst_rs1", rs1_data, 64'd0);
    check_val("rst_rs2", rs2_data, 64'd0);
    wait_init("first");

    // Every entry reads zero after the sweep
    for (int c = 0; c < CN; c++)
      for (int r = 0; r < RN; r += 2) begin
        set_write(1'b0, 0, 0, 0, 0);
        set_read(1'b1, 2'(c), 5'(r), 5'(r + 1));
        run_cycle();
      end

    // Full-width write, read with r0 on the other port, then context isolation
    clk_en = 1'b1;
    set_write(1'b1, 2'd1, 5'd5, 64'h1122334455667788, 8'hFF); set_read(1'b0, 0, 0, 0); run_cycle();
    set_write(1'b0, 0, 0, 0, 0); set_read(1'b1, 2'd1, 5'd5, 5'd0); run_cycle();
    check_val("ctx1_r5", rs1_data, 64'h1122334455667788);
    check_val("ctx1_r0", rs2_data, 64'd0);
    check_val("ctx1_valid", {63'd0, rd_valid}, 64'd1);
    set_read(1'b1, 2'd2, 5'd5, 5'd5); run_cycle();
    check_val("ctx2_r5", rs1_data, 64'd0);

    // Partial byte write
    set_write(1'b1, 2'd0, 5'd7, '1, 8'hFF); set_read(1'b0, 0, 0, 0); run_cycle();
    set_write(1'b1, 2'd0, 5'd7, 64'd0, 8'h0F); run_cycle();
    set_write(1'b0, 0, 0, 0, 0); set_read(1'b1, 2'd0, 5'd7, 5'd7); run_cycle();
    check_val("r7_be", rs1_data, 64'hFFFFFFFF00000000);

    // Writes to r0 are dropped
    set_write(1'b1, 2'd3, 5'd0, 64'hDEAD, 8'hFF); set_read(1'b0, 0, 0, 0); run_cycle();
    set_write(1'b0, 0, 0, 0, 0); set_read(1'b1, 2'd3, 5'd0, 5'd0); run_cycle();
    check_val("r0_write", rs1_data, 64'd0);

    // Same-cycle write/read hit
    set_write(1'b1, 2'd0, 5'd3, 64'hAA, 8'h01); set_read(1'b1, 2'd0, 5'd3, 5'd3); run_cycle();
`ifdef GPR_BYPASS_EN
    check_val("hit_rs1", rs1_data, 64'hAA);
`else
    check_val("hit_rs1", rs1_data, 64'h00);
`endif
    check_val("hit_same_ports", rs2_data, rs1_data);
    set_write(1'b0, 0, 0, 0, 0); run_cycle();
    check_val("hit_after", rs1_data, 64'hAA);

    // clk_en low freezes outputs and blocks writes
    set_read(1'b1, 2'd1, 5'd5, 5'd0); run_cycle();
    clk_en = 1'b0;
    set_write(1'b1, 2'd1, 5'd5, 64'd0, 8'hFF); set_read(1'b1, 2'd1, 5'd7, 5'd3);
    repeat (3) run_cycle();
    check_val("frz_rs1", rs1_data, 64'h1122334455667788);
    check_val("frz_valid", {63'd0, rd_valid}, 64'd1);
    clk_en = 1'b1;
    set_write(1'b0, 0, 0, 0, 0); set_read(1'b1, 2'd1, 5'd5, 5'd5); run_cycle();
    check_val("frz_nowrite", rs1_data, 64'h1122334455667788);
    set_read(1'b0, 2'd0, 5'd0, 5'd0); run_cycle();
    check_val("rden0_valid", {63'd0, rd_valid}, 64'd0);
    check_val("rden0_hold", rs1_data, 64'h1122334455667788);

    // Randomized traffic on a small address window to provoke hits
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(7);
      run_cycle();
    end

    // Reset pulse in the middle of the sweep restarts it
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check_val("mid_no_done", {63'd0, init_done}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_done", {63'd0, init_done}, 64'd0);
    check_val("mid_rst_rs1", rs1_data, 64'd0);
    wait_init("restart");
    for (int i = 0; i < 100; i++) begin
      randomize_inputs(RN - 1);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
